// File: rtl/polaris_csr_pkg.sv
// Shared definitions for the Polaris machine-mode CSR file: addresses,
// CSR operation encodings, interrupt cause codes and status bit positions.
package polaris_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MTIMECMP  = 12'h7C0;
  localparam logic [11:0] CSR_MTIME     = 12'h7C1;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_TIME      = 12'hC01;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  typedef enum logic [1:0] {
    COP_NONE = 2'b00,
    COP_RW   = 2'b01,
    COP_RS   = 2'b10,
    COP_RC   = 2'b11
  } cop_e;

  localparam logic [4:0] CAUSE_MTI    = 5'd7;
  localparam logic [4:0] CAUSE_LOCAL0 = 5'd16;

  localparam int unsigned MSTATUS_MIE  = 3;
  localparam int unsigned MSTATUS_MPIE = 7;
  localparam int unsigned MIP_MTIP     = 7;
  localparam int unsigned MIP_LOCAL0   = 16;

endpackage

// File: rtl/polaris_mtimer.sv
// Prescaled machine timer: mtime advances once every TICK_DIV clocks,
// MTIP is a level compare against mtimecmp. CSR writes beat the increment.
module polaris_mtimer
  import polaris_csr_pkg::*;
#(
  parameter int unsigned CNT_W    = 64,
  parameter int unsigned TICK_DIV = 25
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             mtime_we,
  input  logic             mtimecmp_we,
  input  logic [CNT_W-1:0] wdata,
  output logic [CNT_W-1:0] mtime,
  output logic [CNT_W-1:0] mtimecmp,
  output logic             mtip
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] presc;
  logic          tick;

  assign tick = (presc == PW'(TICK_DIV - 1));
  assign mtip = (mtime >= mtimecmp);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      presc    <= '0;
      mtime    <= '0;
      mtimecmp <= '1;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (mtime_we)
        mtime <= wdata;
      else if (tick)
        mtime <= mtime + 1'b1;
      if (mtimecmp_we)
        mtimecmp <= wdata;
    end
  end

endmodule

// File: rtl/polaris_csr_file.sv
// Machine-mode CSR file and local interrupt controller: CSR decode and
// RW/RS/RC ALU, trap state, counters and a fixed-priority interrupt encoder.
module polaris_csr_file
  import polaris_csr_pkg::*;
#(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned NIRQ      = 4,
  parameter int unsigned CNT_W     = 64,
  parameter int unsigned TICK_DIV  = 25,
  parameter logic [63:0] MTVEC_RST = 64'hFFFF_FFFF_FFFF_FE00
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  input  logic [11:0]     cadr_i,
  input  logic [1:0]      cop_i,
  input  logic            cwe_i,
  input  logic [XLEN-1:0] csrc_i,
  output logic [XLEN-1:0] cdat_o,
  output logic            cvalid_o,
  input  logic            trap_i,
  input  logic            tintr_i,
  input  logic [3:0]      tcause_i,
  input  logic [XLEN-1:0] tepc_i,
  input  logic            mret_i,
  input  logic            retire_i,
  input  logic [NIRQ-1:0] irq_i,
  output logic            take_irq_o,
  output logic [4:0]      irq_cause_o,
  output logic [XLEN-1:0] tvec_o,
  output logic [XLEN-1:0] mepc_o,
  output logic            mie_o,
  output logic            mpie_o
);

  cop_e            cop;
  logic            mst_mie, mst_mpie;
  logic [XLEN-1:0] mtvec_q, mepc_q, mscratch_q, mie_q;
  logic            mcause_intr;
  logic [4:0]      mcause_code;
  logic [CNT_W-1:0] mcycle_q, minstret_q, mtime, mtimecmp;
  logic            mtip;

  logic [XLEN-1:0] rdata, wval, mstatus_rd, mip_rd, irq_mask, pend, tvec_base;
  logic            impl, wr_ok, we, found;
  logic [4:0]      cause;

  assign cop = cop_e'(cop_i);

  always_comb begin
    irq_mask = '0;
    mip_rd   = '0;
    irq_mask[MIP_MTIP] = 1'b1;
    mip_rd[MIP_MTIP]   = mtip;
    for (int unsigned k = 0; k < NIRQ; k++) begin
      irq_mask[MIP_LOCAL0+k] = 1'b1;
      mip_rd[MIP_LOCAL0+k]   = irq_i[k];
    end
    pend  = mip_rd & mie_q;
    // Lowest local line wins; MTIP only when no local line is pending.
    cause = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NIRQ; k++) begin
      if (!found && pend[MIP_LOCAL0+k]) begin
        cause = CAUSE_LOCAL0 + 5'(k);
        found = 1'b1;
      end
    end
    if (!found && pend[MIP_MTIP])
      cause = CAUSE_MTI;
  end

  always_comb begin
    mstatus_rd = '0;
    mstatus_rd[12:11]          = 2'b11;
    mstatus_rd[MSTATUS_MPIE]   = mst_mpie;
    mstatus_rd[MSTATUS_MIE]    = mst_mie;
  end

  always_comb begin
    rdata = '0;
    impl  = 1'b1;
    wr_ok = 1'b1;
    case (cadr_i)
      CSR_MSTATUS:  rdata = mstatus_rd;
      CSR_MIE:      rdata = mie_q;
      CSR_MTVEC:    rdata = mtvec_q;
      CSR_MSCRATCH: rdata = mscratch_q;
      CSR_MEPC:     rdata = mepc_q;
      CSR_MCAUSE:   rdata = {mcause_intr, {(XLEN-6){1'b0}}, mcause_code};
      CSR_MTIMECMP: rdata = XLEN'(mtimecmp);
      CSR_MTIME:    rdata = XLEN'(mtime);
      CSR_MCYCLE:   rdata = XLEN'(mcycle_q);
      CSR_MINSTRET: rdata = XLEN'(minstret_q);
      CSR_MIP: begin
        rdata = mip_rd;
        wr_ok = 1'b0;
      end
      CSR_CYCLE: begin
        rdata = XLEN'(mcycle_q);
        wr_ok = 1'b0;
      end
      CSR_TIME: begin
        rdata = XLEN'(mtime);
        wr_ok = 1'b0;
      end
      CSR_INSTRET: begin
        rdata = XLEN'(minstret_q);
        wr_ok = 1'b0;
      end
      CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID, CSR_MHARTID: wr_ok = 1'b0;
      default: begin
        impl  = 1'b0;
        wr_ok = 1'b0;
      end
    endcase
  end

  always_comb begin
    case (cop)
      COP_RW:  wval = csrc_i;
      COP_RS:  wval = rdata | csrc_i;
      COP_RC:  wval = rdata & ~csrc_i;
      default: wval = rdata;
    endcase
  end

  assign we       = cwe_i & impl & wr_ok & (cop != COP_NONE) & ~trap_i;
  assign cvalid_o = impl & (~cwe_i | (wr_ok & (cop != COP_NONE)));
  assign cdat_o   = rdata;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      mst_mie     <= 1'b0;
      mst_mpie    <= 1'b0;
      mtvec_q     <= MTVEC_RST[XLEN-1:0];
      mepc_q      <= '0;
      mscratch_q  <= '0;
      mie_q       <= '0;
      mcause_intr <= 1'b0;
      mcause_code <= '0;
    end else if (trap_i) begin
      mepc_q      <= {tepc_i[XLEN-1:2], 2'b00};
      mcause_intr <= tintr_i;
      mcause_code <= tintr_i ? cause : {1'b0, tcause_i};
      mst_mpie    <= mst_mie;
      mst_mie     <= 1'b0;
    end else begin
      if (mret_i) begin
        mst_mie  <= mst_mpie;
        mst_mpie <= 1'b1;
      end
      if (we) begin
        case (cadr_i)
          CSR_MSTATUS: begin
            mst_mie  <= wval[MSTATUS_MIE];
            mst_mpie <= wval[MSTATUS_MPIE];
          end
          CSR_MIE:      mie_q      <= wval & irq_mask;
          CSR_MTVEC:    mtvec_q    <= {wval[XLEN-1:2], 1'b0, wval[0]};
          CSR_MSCRATCH: mscratch_q <= wval;
          CSR_MEPC:     mepc_q     <= {wval[XLEN-1:2], 2'b00};
          CSR_MCAUSE: begin
            mcause_intr <= wval[XLEN-1];
            mcause_code <= wval[4:0];
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mcycle_q <= (we && cadr_i == CSR_MCYCLE) ? wval[CNT_W-1:0] : mcycle_q + 1'b1;
      if (we && cadr_i == CSR_MINSTRET)
        minstret_q <= wval[CNT_W-1:0];
      else if (retire_i)
        minstret_q <= minstret_q + 1'b1;
    end
  end

  polaris_mtimer #(
    .CNT_W    (CNT_W),
    .TICK_DIV (TICK_DIV)
  ) u_mtimer (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .mtime_we    (we && cadr_i == CSR_MTIME),
    .mtimecmp_we (we && cadr_i == CSR_MTIMECMP),
    .wdata       (wval[CNT_W-1:0]),
    .mtime       (mtime),
    .mtimecmp    (mtimecmp),
    .mtip        (mtip)
  );

  assign tvec_base   = {mtvec_q[XLEN-1:2], 2'b00};
  assign tvec_o      = (mtvec_q[0] & mcause_intr)
                       ? tvec_base + {{(XLEN-7){1'b0}}, mcause_code, 2'b00}
                       : tvec_base;
  assign take_irq_o  = mst_mie & (|pend);
  assign irq_cause_o = cause;
  assign mepc_o      = mepc_q;
  assign mie_o       = mst_mie;
  assign mpie_o      = mst_mpie;

endmodule

// File: tb/tb_polaris_csr_file.sv
// Scenario bench for polaris_csr_file: expected values are queued as stimulus
// is driven and popped when the corresponding DUT output is sampled.
module tb_polaris_csr_file;

  localparam logic [63:0] MTVEC_RST = 64'hFFFF_FFFF_FFFF_FE00;

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic [11:0] cadr_i;
  logic [1:0]  cop_i;
  logic        cwe_i;
  logic [63:0] csrc_i;
  logic [63:0] cdat_o;
  logic        cvalid_o;
  logic        trap_i, tintr_i;
  logic [3:0]  tcause_i;
  logic [63:0] tepc_i;
  logic        mret_i, retire_i;
  logic [3:0]  irq_i;
  logic        take_irq_o;
  logic [4:0]  irq_cause_o;
  logic [63:0] tvec_o, mepc_o;
  logic        mie_o, mpie_o;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned cyc = 0;
  logic [63:0] exp_q[$];
  logic [63:0] e;

  polaris_csr_file #(
    .XLEN      (64),
    .NIRQ      (4),
    .CNT_W     (64),
    .TICK_DIV  (25),
    .MTVEC_RST (MTVEC_RST)
  ) dut (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .cadr_i      (cadr_i),
    .cop_i       (cop_i),
    .cwe_i       (cwe_i),
    .csrc_i      (csrc_i),
    .cdat_o      (cdat_o),
    .cvalid_o    (cvalid_o),
    .trap_i      (trap_i),
    .tintr_i     (tintr_i),
    .tcause_i    (tcause_i),
    .tepc_i      (tepc_i),
    .mret_i      (mret_i),
    .retire_i    (retire_i),
    .irq_i       (irq_i),
    .take_irq_o  (take_irq_o),
    .irq_cause_o (irq_cause_o),
    .tvec_o      (tvec_o),
    .mepc_o      (mepc_o),
    .mie_o       (mie_o),
    .mpie_o      (mpie_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    cyc++;
    #1;
  endtask

  task automatic idle();
    cadr_i = 12'h000; cop_i = 2'b00; cwe_i = 1'b0; csrc_i = '0;
    trap_i = 1'b0; tintr_i = 1'b0; tcause_i = '0; tepc_i = '0;
    mret_i = 1'b0; retire_i = 1'b0;
  endtask

  task automatic drive_csr(input logic [11:0] a, input logic [1:0] op, input logic [63:0] s);
    cadr_i = a; cop_i = op; csrc_i = s; cwe_i = 1'b1;
  endtask

  task automatic read_csr(input logic [11:0] a);
    cadr_i = a; cop_i = 2'b00; cwe_i = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    idle();
    irq_i = '0;
    reset_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    reset_ni = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    exp_q.push_back(64'h0);
    exp_q.push_back(MTVEC_RST);
    exp_q.push_back(64'h0);
    e = exp_q.pop_front(); vectors++;
    if ({cvalid_o, take_irq_o, irq_cause_o, mie_o, mpie_o, cdat_o} !== {1'b0, 1'b0, 5'd0, 1'b0, 1'b0, e}) begin
      miscompares++;
      $display("FAIL reset_flags: got valid=%b take=%b cause=%0d mie=%b mpie=%b dat=%h, want all 0",
               cvalid_o, take_irq_o, irq_cause_o, mie_o, mpie_o, cdat_o);
    end
    e = exp_q.pop_front(); vectors++;
    if (tvec_o !== e) begin miscompares++; $display("FAIL reset_tvec: got %h want %h", tvec_o, e); end
    e = exp_q.pop_front(); vectors++;
    if (mepc_o !== e) begin miscompares++; $display("FAIL reset_mepc: got %h want %h", mepc_o, e); end
    exp_q.push_back(64'h1800);
    read_csr(12'h300);
    e = exp_q.pop_front(); vectors++;
    if (cdat_o !== e) begin miscompares++; $display("FAIL reset_mstatus: got %h want %h", cdat_o, e); end
    exp_q.push_back('1);
    read_csr(12'h7C0);
    e = exp_q.pop_front(); vectors++;
    if (cdat_o !== e) begin miscompares++; $display("FAIL reset_mtimecmp: got %h want %h", cdat_o, e); end
  endtask

  task automatic test_rs_rc();
    logic [63:0] vals[3];
    logic [1:0]  ops[3];
    vals = '{64'hF0, 64'h0F, 64'h3C};
    ops  = '{2'b01, 2'b10, 2'b11};
    exp_q.push_back(64'h00); exp_q.push_back(64'hF0);
    exp_q.push_back(64'hF0); exp_q.push_back(64'hFF);
    exp_q.push_back(64'hFF); exp_q.push_back(64'hC3);
    for (int i = 0; i < 3; i++) begin
      drive_csr(12'h340, ops[i], vals[i]);
      #1;
      e = exp_q.pop_front(); vectors++;
      if (cdat_o !== e || cvalid_o !== 1'b1) begin
        miscompares++;
        $display("FAIL mscratch_old_%0d: got %h valid=%b want %h valid=1", i, cdat_o, cvalid_o, e);
      end
      tick(); idle();
      read_csr(12'h340);
      e = exp_q.pop_front(); vectors++;
      if (cdat_o !== e) begin miscompares++; $display("FAIL mscratch_new_%0d: got %h want %h", i, cdat_o, e); end
    end
  endtask

  task automatic test_irq_trap();
    drive_csr(12'h300, 2'b10, 64'h8); tick();
    drive_csr(12'h304, 2'b10, 64'h2_0000); tick(); idle();
    irq_i = 4'b0110;
    #1;
    exp_q.push_back({58'd0, 1'b1, 5'd17});
    e = exp_q.pop_front(); vectors++;
    if ({take_irq_o, irq_cause_o} !== e[5:0]) begin
      miscompares++; $display("FAIL irq_take: got take=%b cause=%0d want take=1 cause=17", take_irq_o, irq_cause_o);
    end
    trap_i = 1'b1; tintr_i = 1'b1; tepc_i = 64'h2003;
    tick(); idle();
    irq_i = '0;
    exp_q.push_back(64'h8000_0000_0000_0011);
    exp_q.push_back(64'h2000);
    read_csr(12'h342);
    e = exp_q.pop_front(); vectors++;
    if (cdat_o !== e) begin miscompares++; $display("FAIL trap_mcause: got %h want %h", cdat_o, e); end
    e = exp_q.pop_front(); vectors++;
    if (mepc_o !== e || mie_o !== 1'b0 || mpie_o !== 1'b1) begin
      miscompares++; $display("FAIL trap_state: got mepc=%h mie=%b mpie=%b want mepc=%h mie=0 mpie=1", mepc_o, mie_o, mpie_o, e);
    end
    drive_csr(12'h305, 2'b01, 64'h1003); tick(); idle();
    exp_q.push_back(64'h1044);
    exp_q.push_back(64'h1001);
    read_csr(12'h305);
    e = exp_q.pop_front(); vectors++;
    if (tvec_o !== e) begin miscompares++; $display("FAIL tvec_vectored: got %h want %h", tvec_o, e); end
    e = exp_q.pop_front(); vectors++;
    if (cdat_o !== e) begin miscompares++; $display("FAIL mtvec_bit1: got %h want %h", cdat_o, e); end
    mret_i = 1'b1; tick(); idle(); #1;
    exp_q.push_back(64'h3);
    e = exp_q.pop_front(); vectors++;
    if ({mie_o, mpie_o} !== e[1:0]) begin
      miscompares++; $display("FAIL mret: got mie=%b mpie=%b want mie=1 mpie=1", mie_o, mpie_o);
    end
  endtask

  task automatic test_trap_priority();
    drive_csr(12'h341, 2'b01, 64'h100); tick(); idle();
    drive_csr(12'h341, 2'b01, 64'h5550);
    trap_i = 1'b1; tintr_i = 1'b0; tcause_i = 4'd2; tepc_i = 64'h3004; mret_i = 1'b1;
    tick(); idle();
    exp_q.push_back(64'h3004);
    exp_q.push_back(64'h2);
    read_csr(12'h342);
    e = exp_q.pop_front(); vectors++;
    if (mepc_o !== e || mie_o !== 1'b0 || mpie_o !== 1'b1) begin
      miscompares++; $display("FAIL trap_beats_all: got mepc=%h mie=%b mpie=%b want mepc=%h mie=0 mpie=1", mepc_o, mie_o, mpie_o, e);
    end
    e = exp_q.pop_front(); vectors++;
    if (cdat_o !== e) begin miscompares++; $display("FAIL exc_mcause: got %h want %h", cdat_o, e); end
  endtask

  task automatic test_read_only();
    drive_csr(12'hF14, 2'b01, 64'h55); #1;
    vectors++;
    if (cvalid_o !== 1'b0) begin miscompares++; $display("FAIL ro_write_valid: got %b want 0", cvalid_o); end
    tick(); idle();
    exp_q.push_back(64'h0);
    read_csr(12'hF14);
    e = exp_q.pop_front(); vectors++;
    if (cdat_o !== e || cvalid_o !== 1'b1) begin
      miscompares++; $display("FAIL ro_read: got %h valid=%b want %h valid=1", cdat_o, cvalid_o, e);
    end
    exp_q.push_back(64'h0);
    read_csr(12'h7FF);
    e = exp_q.pop_front(); vectors++;
    if (cdat_o !== e || cvalid_o !== 1'b0) begin
      miscompares++; $display("FAIL unimpl_read: got %h valid=%b want %h valid=0", cdat_o, cvalid_o, e);
    end
    drive_csr(12'h340, 2'b00, 64'h0); #1;
    vectors++;
    if (cvalid_o !== 1'b0) begin miscompares++; $display("FAIL nop_write_valid: got %b want 0", cvalid_o); end
    tick(); idle();
    exp_q.push_back(64'hC3);
    read_csr(12'h340);
    e = exp_q.pop_front(); vectors++;
    if (cdat_o !== e) begin miscompares++; $display("FAIL nop_write_kept: got %h want %h", cdat_o, e); end
  endtask

  task automatic test_counters();
    drive_csr(12'hB00, 2'b01, '1); tick(); idle();
    exp_q.push_back('1);
    exp_q.push_back(64'h0);
    read_csr(12'hB00);
    e = exp_q.pop_front(); vectors++;
    if (cdat_o !== e) begin miscompares++; $display("FAIL mcycle_write: got %h want %h", cdat_o, e); end
    tick();
    read_csr(12'hC00);
    e = exp_q.pop_front(); vectors++;
    if (cdat_o !== e) begin miscompares++; $display("FAIL mcycle_wrap: got %h want %h", cdat_o, e); end
    drive_csr(12'hB02, 2'b01, 64'h5); retire_i = 1'b1; tick(); idle();
    exp_q.push_back(64'h5);
    exp_q.push_back(64'h6);
    read_csr(12'hC02);
    e = exp_q.pop_front(); vectors++;
    if (cdat_o !== e) begin miscompares++; $display("FAIL minstret_write_wins: got %h want %h", cdat_o, e); end
    retire_i = 1'b1; tick(); retire_i = 1'b0;
    read_csr(12'hB02);
    e = exp_q.pop_front(); vectors++;
    if (cdat_o !== e) begin miscompares++; $display("FAIL minstret_inc: got %h want %h", cdat_o, e); end
  endtask

  task automatic test_reset_mid();
    drive_csr(12'h300, 2'b10, 64'h8); tick();
    drive_csr(12'hB00, 2'b01, 64'h1234); tick(); idle();
    read_csr(12'hB00);
    exp_q.push_back(64'h1234);
    e = exp_q.pop_front(); vectors++;
    if (cdat_o !== e || mie_o !== 1'b1) begin
      miscompares++; $display("FAIL pre_reset: got mcycle=%h mie=%b want %h mie=1", cdat_o, mie_o, e);
    end
    #2 reset_ni = 1'b0;
    #1;
    exp_q.push_back(64'h0);
    exp_q.push_back(MTVEC_RST);
    e = exp_q.pop_front(); vectors++;
    if (cdat_o !== e || mie_o !== 1'b0 || mepc_o !== 64'h0) begin
      miscompares++; $display("FAIL async_reset_state: got mcycle=%h mie=%b mepc=%h want 0", cdat_o, mie_o, mepc_o);
    end
    e = exp_q.pop_front(); vectors++;
    if (tvec_o !== e) begin miscompares++; $display("FAIL async_reset_tvec: got %h want %h", tvec_o, e); end
  endtask

  task automatic test_timer();
    do_reset();
    drive_csr(12'h7C0, 2'b01, 64'h3); tick();
    drive_csr(12'h304, 2'b01, 64'h80); tick(); idle();
    while (cyc < 74) tick();
    exp_q.push_back(64'h0);
    exp_q.push_back(64'h80);
    exp_q.push_back(64'd75);
    read_csr(12'h344);
    e = exp_q.pop_front(); vectors++;
    if (cdat_o !== e || irq_cause_o !== 5'd0) begin
      miscompares++; $display("FAIL mtip_early: got mip=%h cause=%0d want mip=%h cause=0", cdat_o, irq_cause_o, e);
    end
    tick();
    read_csr(12'h344);
    e = exp_q.pop_front(); vectors++;
    if (cdat_o !== e || irq_cause_o !== 5'd7 || take_irq_o !== 1'b0) begin
      miscompares++; $display("FAIL mtip_rise: got mip=%h cause=%0d take=%b want mip=%h cause=7 take=0", cdat_o, irq_cause_o, take_irq_o, e);
    end
    read_csr(12'hB00);
    e = exp_q.pop_front(); vectors++;
    if (cdat_o !== e) begin miscompares++; $display("FAIL mcycle_count: got %h want %h", cdat_o, e); end
    while (cyc < 99) tick();
    drive_csr(12'h7C1, 2'b01, 64'h50); tick(); idle();
    exp_q.push_back(64'h50);
    exp_q.push_back(64'h50);
    exp_q.push_back(64'h51);
    read_csr(12'hC01);
    e = exp_q.pop_front(); vectors++;
    if (cdat_o !== e) begin miscompares++; $display("FAIL mtime_write_on_tick: got %h want %h", cdat_o, e); end
    while (cyc < 124) tick();
    read_csr(12'hC01);
    e = exp_q.pop_front(); vectors++;
    if (cdat_o !== e) begin miscompares++; $display("FAIL mtime_hold: got %h want %h", cdat_o, e); end
    tick();
    read_csr(12'hC01);
    e = exp_q.pop_front(); vectors++;
    if (cdat_o !== e) begin miscompares++; $display("FAIL mtime_next_tick: got %h want %h", cdat_o, e); end
  endtask

  initial begin
    idle();
    irq_i    = '0;
    reset_ni = 1'b0;
    test_reset();
    test_rs_rc();
    test_irq_trap();
    test_trap_priority();
    test_read_only();
    test_counters();
    test_reset_mid();
    test_timer();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
